speed_period_sequencer: RTL
===========================

# speed_period_sequencer

Measures the commutation period between accepted `comm_edge` pulses and keeps a moving average over the last 2^AVG_SHIFT periods. Drives the 32-bit sequential divider that sits directly downstream of it to compute speed = RPM_CONST / average period, then latches the quotient as the speed estimate. It owns the divider's reset and start handshake, including re-arming the divider between divisions.

## Interface
- RPM_CONST, 32'd3_000_000_000, dividend supplied to the divider (clock rate × 60 / pole pairs, pre-scaled)
- AVG_SHIFT, 2, log2 of the averaging depth (depth 4); legal 0..3
- MIN_PERIOD, 32'd500, blanking: edges with count < MIN_PERIOD are ignored; must be ≥1
- STALL_LIMIT, 32'd50_000_000, count at which the motor is declared stalled
- DIV_WDOG, 6'd48, maximum RUN cycles before `div_error`
- clk  in  1  single clock domain
- reset  in  1  asynchronous, active-low
- comm_edge  in  1  synchronized one-cycle commutation pulse
- div_reset  out  1  active-high reset to the divider; also loads the dividend into it
- div_start  out  1  held high while the divider runs
- div_dividend  out  32  constant RPM_CONST
- div_divisor  out  32  average period, stable from CLEAR until IDLE
- div_quotient  in  32  divider quotient
- div_done  in  1  divider completion level
- speed  out  32  latest quotient; 0 when stalled
- speed_valid  out  1  set once the ring is full and the first division has completed
- speed_update  out  1  one-cycle pulse when `speed` changes
- stalled  out  1  high while the count ≥ STALL_LIMIT
- div_error  out  1  sticky; set on watchdog expiry, cleared only by reset

## Operation
- Period counter: 32-bit, increments every cycle and saturates at 0xFFFFFFFF. On an accepted edge it restarts at 1.
- Accepted edge:
  - the captured period enters the ring;
  - running sum (32+AVG_SHIFT bits) is updated as sum − oldest + new;
  - `fill` count increments until it reaches depth.
- Average: sum >> AVG_SHIFT, truncated, never 0.
- Division request: raised on an accepted edge when `fill` = depth. A request arriving while the FSM is busy sets a one-deep `pending` flag. The latest average is used when the request is serviced.
- FSM states:
  - IDLE: on request or pending, latch divisor → CLEAR.
  - CLEAR: `div_reset`=1 for exactly one cycle → RUN.
  - RUN: `div_start`=1 until `div_done`=1 → LATCH. If the watchdog reaches DIV_WDOG, set `div_error` → IDLE with speed unchanged.
  - LATCH: speed ← `div_quotient`, pulse `speed_update`, set `speed_valid`, clear pending → IDLE.
- Stall: when the count reaches STALL_LIMIT:
  - stalled=1, speed=0, speed_valid=0, one `speed_update` pulse;
  - ring cleared, `fill`=0.
  - Any division in flight completes but its result is discarded.
- Stall exit: the next edge clears `stalled`. That edge only restarts the counter and is not captured.

## Timing
- Reset values: div_reset=1 (divider held in reset while reset is low), div_start=0, div_divisor=0, speed=0, speed_valid=0, speed_update=0, stalled=0, div_error=0, FSM=IDLE, counter=0, fill=0, pending=0.
- Edge accepted in cycle N → ring and sum updated at N+1 → CLEAR at N+2 → RUN from N+3 → LATCH one cycle after `div_done` is sampled high. The divider needs 33 start cycles plus 1 cycle for done, so `speed_update` arrives at N+38 nominal.
- Edge and stall in the same cycle: the edge wins; the counter restarts and no stall is declared.
- Edge in the same cycle as LATCH: latch completes and the edge sets `pending`.
- Reset asserted mid-RUN: everything returns to reset values immediately and the divider is held in reset.

## Structure
- Package `speed_pkg`:
  - FSM state enum {IDLE, CLEAR, RUN, LATCH};
  - widths: PERIOD_W=32, SUM_W=PERIOD_W+AVG_SHIFT, WDOG_W=6.
- Sub-module `period_avg_ring`: depth-2^AVG_SHIFT circular buffer with write pointer, `fill` count, running sum and clear input. Outputs the average and a `full` flag.

## Test plan
- Edges every 1000 cycles with RPM_CONST=3_000_000 → first `speed_update` after the 4th edge, speed=3000, speed_valid=1.
- Periods 1000, 1000, 1000, 2000 → average 1250, speed=2400. A 500-cycle glitch edge (MIN_PERIOD=600) is ignored and speed is unchanged.
- Two edges 20 cycles apart while the divider is busy → exactly one extra division using the newer average, no lost `speed_update`.
- No edges for STALL_LIMIT cycles → stalled=1, speed=0, one update pulse. The next edge clears `stalled`; speed_valid returns only after 4 further captured periods.
- `div_done` tied low → div_error=1 after 48 RUN cycles, FSM back in IDLE, speed held. Reset low mid-RUN → all outputs at reset values, div_reset=1.

Source files
------------

// File: rtl/speed_pkg.sv
// Shared types and widths for the commutation-period speed estimator.
package speed_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    LATCH
  } fsm_state_t;

  localparam int PERIOD_W      = 32;
  localparam int DEF_AVG_SHIFT = 2;
  localparam int SUM_W         = PERIOD_W + DEF_AVG_SHIFT;
  localparam int WDOG_W        = 6;

  localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

  // Running-sum width for a given averaging depth exponent.
  function automatic int sum_width(input int shift);
    return PERIOD_W + shift;
  endfunction

endpackage

// File: rtl/speed_period_sequencer_ring.sv
// Circular buffer of the last 2^AVG_SHIFT periods with a running sum,
// fill tracking and a never-zero truncated average.
module period_avg_ring
  import speed_pkg::*;
#(
  parameter int AVG_SHIFT = DEF_AVG_SHIFT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clear,
  input  logic                i_push,
  input  logic [PERIOD_W-1:0] i_period,
  output logic [PERIOD_W-1:0] o_avg,
  output logic                o_full
);

  localparam int DEPTH  = 1 << AVG_SHIFT;
  localparam int PTR_W  = (AVG_SHIFT > 0) ? AVG_SHIFT : 1;
  localparam int FILL_W = AVG_SHIFT + 1;
  localparam int S_W    = sum_width(AVG_SHIFT);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);

  logic [PERIOD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [FILL_W-1:0]   r_fill;
  logic [S_W-1:0]      r_sum;

  logic [PERIOD_W-1:0] w_oldest;
  logic [S_W-1:0]      w_sum_next;
  logic [PERIOD_W-1:0] w_avg_raw;

  // Until the ring is full the slot being overwritten holds nothing counted in the sum.
  assign w_oldest   = o_full ? r_mem[r_wr_ptr] : '0;
  assign w_sum_next = r_sum - S_W'(w_oldest) + S_W'(i_period);
  assign w_avg_raw  = r_sum[S_W-1:AVG_SHIFT];
  assign o_avg      = (w_avg_raw == '0) ? PERIOD_W'(1) : w_avg_raw;
  assign o_full     = (r_fill == FILL_FULL);

  always_ff @(posedge clk) begin
    if (i_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_period;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_fill   <= '0;
      r_sum    <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_fill   <= '0;
      r_sum    <= '0;
    end else if (i_push) begin
      r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      if (!o_full) begin
        r_fill <= r_fill + FILL_W'(1);
      end
      r_sum <= w_sum_next;
    end
  end

endmodule

// File: rtl/speed_period_sequencer.sv
// Commutation period measurement, moving average and divider sequencing
// that turns the average period into a latched speed estimate.
module speed_period_sequencer
  import speed_pkg::*;
#(
  parameter logic [31:0]       RPM_CONST   = 32'd3_000_000_000,
  parameter int                AVG_SHIFT   = 2,
  parameter logic [31:0]       MIN_PERIOD  = 32'd500,
  parameter logic [31:0]       STALL_LIMIT = 32'd50_000_000,
  parameter logic [WDOG_W-1:0] DIV_WDOG    = 6'd48
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_comm_edge,
  input  logic [31:0] i_div_quotient,
  input  logic        i_div_done,
  output logic        o_div_reset,
  output logic        o_div_start,
  output logic [31:0] o_div_dividend,
  output logic [31:0] o_div_divisor,
  output logic [31:0] o_speed,
  output logic        o_speed_valid,
  output logic        o_speed_update,
  output logic        o_stalled,
  output logic        o_div_error
);

  logic [PERIOD_W-1:0] r_count;
  logic                r_stalled;
  logic                r_req;

  fsm_state_t          r_state;
  logic                r_div_reset;
  logic                r_div_start;
  logic [31:0]         r_divisor;
  logic [31:0]         r_speed;
  logic                r_speed_valid;
  logic                r_speed_update;
  logic                r_div_error;
  logic                r_pending;
  logic                r_discard;
  logic [WDOG_W-1:0]   r_wdog;

  logic [PERIOD_W-1:0] w_count_inc;
  logic                w_edge_live;
  logic                w_exit;
  logic                w_accept;
  logic                w_stall_hit;
  logic [PERIOD_W-1:0] w_avg;
  logic                w_full;
  logic                w_request;
  logic                w_wdog_expire;
  logic                w_service;
  logic                w_busy_next;

  assign w_count_inc = (r_count == PERIOD_MAX) ? r_count : r_count + 32'd1;
  assign w_edge_live = i_comm_edge && (r_count >= MIN_PERIOD);
  assign w_exit      = i_comm_edge && r_stalled;
  assign w_accept    = w_edge_live && !r_stalled;
  assign w_stall_hit = !r_stalled && !w_edge_live && (w_count_inc >= STALL_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_stalled <= 1'b0;
      r_req     <= 1'b0;
    end else begin
      r_req   <= w_accept;
      r_count <= (w_edge_live || w_exit) ? PERIOD_W'(1) : w_count_inc;
      if (w_exit) begin
        r_stalled <= 1'b0;
      end else if (w_stall_hit) begin
        r_stalled <= 1'b1;
      end
    end
  end

  period_avg_ring #(
    .AVG_SHIFT (AVG_SHIFT)
  ) u_ring (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_stall_hit),
    .i_push   (w_accept),
    .i_period (r_count),
    .o_avg    (w_avg),
    .o_full   (w_full)
  );

  // r_req lines up with the ring update, so w_full already includes the new period.
  assign w_request     = r_req && w_full;
  assign w_wdog_expire = (r_state == RUN) && !i_div_done && (r_wdog == DIV_WDOG - 6'd1);
  assign w_service     = (r_state == IDLE) && (w_request || r_pending);
  assign w_busy_next   = w_service || (r_state == CLEAR) || ((r_state == RUN) && !w_wdog_expire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_div_reset    <= 1'b1;
      r_div_start    <= 1'b0;
      r_divisor      <= '0;
      r_speed        <= '0;
      r_speed_valid  <= 1'b0;
      r_speed_update <= 1'b0;
      r_div_error    <= 1'b0;
      r_pending      <= 1'b0;
      r_discard      <= 1'b0;
      r_wdog         <= '0;
    end else begin
      r_speed_update <= 1'b0;
      r_div_reset    <= 1'b0;
      if (w_request && (r_state != IDLE)) begin
        r_pending <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_service) begin
            r_divisor   <= w_avg;
            r_pending   <= 1'b0;
            r_div_reset <= 1'b1;
            r_state     <= CLEAR;
          end
        end
        CLEAR: begin
          r_div_start <= 1'b1;
          r_wdog      <= '0;
          r_state     <= RUN;
        end
        RUN: begin
          if (i_div_done) begin
            r_div_start <= 1'b0;
            r_state     <= LATCH;
          end else if (w_wdog_expire) begin
            r_div_start <= 1'b0;
            r_div_error <= 1'b1;
            r_discard   <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_wdog <= r_wdog + 6'd1;
          end
        end
        LATCH: begin
          if (!r_discard && !w_stall_hit) begin
            r_speed        <= i_div_quotient;
            r_speed_update <= 1'b1;
            r_speed_valid  <= 1'b1;
          end
          r_discard <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // A stall overrides any latch and poisons a division still in flight.
      if (w_stall_hit) begin
        r_speed        <= '0;
        r_speed_valid  <= 1'b0;
        r_speed_update <= 1'b1;
        r_pending      <= 1'b0;
        r_discard      <= w_busy_next;
      end
    end
  end

  assign o_div_reset    = r_div_reset;
  assign o_div_start    = r_div_start;
  assign o_div_dividend = RPM_CONST;
  assign o_div_divisor  = r_divisor;
  assign o_speed        = r_speed;
  assign o_speed_valid  = r_speed_valid;
  assign o_speed_update = r_speed_update;
  assign o_stalled      = r_stalled;
  assign o_div_error    = r_div_error;

endmodule
